// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional
// even-parity bit and stop bit, decoded from a line that idles high. The
// received byte is presented on a valid/ready output with sticky overrun
// and single-cycle frame/parity error pulses.
module serial_frame_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              s_in,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              overrun,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic              r_sync1;
  logic              r_sync2;
  logic [2:0]        r_state;
  logic [CW-1:0]     r_clk_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;

  logic w_s_sync;
  logic w_tick;
  logic w_stop_done;
  logic w_par_ok;
  logic w_good;
  logic w_hs;
  logic w_load;

  assign w_s_sync = r_sync2;

  // Two-flop synchronizer on the serial line; resets to the idle level and
  // freezes with ena so a paused frame resumes with the same history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else if (ena) begin
      r_sync1 <= s_in;
      r_sync2 <= r_sync1;
    end
  end

  // Sample strobe, frame completion and handshake decisions.
  always_comb begin
    w_tick      = 1'b0;
    w_stop_done = 1'b0;
    w_par_ok    = 1'b1;
    w_good      = 1'b0;
    w_hs        = 1'b0;
    w_load      = 1'b0;
    // START waits half a bit to land mid-bit; later states wait a full bit.
    if (r_state == S_START) w_tick = (r_clk_cnt == HALF_M1);
    else                    w_tick = (r_clk_cnt == FULL_M1);
    w_stop_done = ena && (r_state == S_STOP) && w_tick;
    // r_par holds XOR of data bits and parity bit; even parity means zero.
    if (PARITY_EN != 0) w_par_ok = ~r_par;
    w_good = w_stop_done && w_s_sync && w_par_ok;
    w_hs   = ena && rx_valid && rx_ready;
    // A good frame may load if the slot is empty or is being drained now.
    w_load = w_good && (!rx_valid || w_hs);
  end

  // Receive FSM with bit-time counter, data shift buffer and parity accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (!w_s_sync) begin
            r_state   <= S_START;
            r_clk_cnt <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            // A start bit that has gone high again by mid-bit is a glitch.
            if (w_s_sync) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              r_par     <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            // Shift in at the MSB so the first bit ends up at bit0.
            r_shift   <= {w_s_sync, r_shift[DATA_W-1:1]};
            r_par     <= r_par ^ w_s_sync;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            r_par     <= r_par ^ w_s_sync;
            r_state   <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  // Output holding register, sticky overrun and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      // Pulses drop every cycle, including while ena is low.
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (ena) begin
        frame_err  <= w_stop_done && !w_s_sync;
        parity_err <= w_stop_done && w_s_sync && !w_par_ok;
        if (w_load) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end else if (w_hs) begin
          rx_valid <= 1'b0;
        end
        // A good frame with nowhere to go is dropped and flagged.
        if (w_good && !w_load) overrun <= 1'b1;
        else if (w_hs)         overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed frames from the test
// plan plus randomized frames, checked against a frame-level model.
module tb_serial_frame_rx;

  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int PEN = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          s_in = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          overrun;
  logic          frame_err;
  logic          parity_err;

  serial_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_EN(PEN)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s_in(s_in), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level model state
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_ovr   = 1'b0;
  int            exp_fe  = 0;
  int            exp_pe  = 0;

  // Observation: pulse counts, pulse widths, consumed bytes, data stability.
  int            fe_cnt = 0;
  int            pe_cnt = 0;
  int            wide   = 0;
  logic          prev_fe = 1'b0, prev_pe = 1'b0;
  logic          pv = 1'b0, phs = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [DW-1:0] got_q[$];

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
    if ((frame_err && prev_fe) || (parity_err && prev_pe)) wide++;
    prev_fe = frame_err;
    prev_pe = parity_err;
    if (rst_n && pv && !phs && rx_valid) chk("stable", rx_data, pd);
    if (rst_n && rx_valid && rx_ready && ena) got_q.push_back(rx_data);
    pv  = rx_valid;
    phs = rx_valid && rx_ready && ena;
    pd  = rx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_in = b;
    repeat (CPB) tick();
  endtask

  task automatic idle(input int n);
    s_in = 1'b1;
    repeat (n) tick();
  endtask

  // Drive one frame; optionally pause ena inside a data bit or reset mid-frame.
  task automatic send_frame(input logic [DW-1:0] d, input bit pflip, input logic stopb,
                            input int ena_bit, input int rst_bit);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) begin
      if (i == rst_bit) begin
        s_in  = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
      if (i == ena_bit) begin
        s_in = d[i];
        repeat (CPB / 2) tick();
        ena = 1'b0;
        repeat (10) tick();
        ena = 1'b1;
        repeat (CPB - CPB / 2) tick();
      end else begin
        send_bit(d[i]);
      end
    end
    if (PEN != 0) send_bit((^d) ^ pflip);
    send_bit(stopb);
  endtask

  function automatic void apply_frame(input logic [DW-1:0] d, input bit pflip, input logic stopb);
    if (!stopb)                     exp_fe++;
    else if (PEN != 0 && pflip)     exp_pe++;
    else if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = d;
    end else                        m_ovr = 1'b1;
  endfunction

  task automatic pop();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, rx_valid, m_valid);
    if (m_valid) chk({tag, ".data"}, rx_data, m_data);
    chk({tag, ".ovr"}, overrun, m_ovr);
    chk({tag, ".fe_cnt"}, fe_cnt, exp_fe);
    chk({tag, ".pe_cnt"}, pe_cnt, exp_pe);
    chk({tag, ".wide"}, wide, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int kind;
    logic [DW-1:0] b2b[3];
    b2b[0] = 8'h01; b2b[1] = 8'h80; b2b[2] = 8'hFF;

    // Reset with the line toggling
    rst_n = 1'b0;
    repeat (3) begin
      s_in = ~s_in;
      tick();
    end
    chk("rst.data", rx_data, 0);
    chk("rst.valid", rx_valid, 0);
    chk("rst.ovr", overrun, 0);
    chk("rst.fe", frame_err, 0);
    chk("rst.pe", parity_err, 0);
    rst_n = 1'b1;
    idle(20);
    check_state("idle");

    // Good frame, held until consumed
    send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
    idle(4);
    apply_frame(8'hA5, 1'b0, 1'b1);
    check_state("a5");
    pop();
    chk("a5.drain", rx_valid, 0);

    // Parity error, then framing error
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    idle(4);
    apply_frame(8'h3C, 1'b1, 1'b1);
    check_state("perr");
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    idle(6);
    apply_frame(8'h3C, 1'b0, 1'b0);
    check_state("ferr");

    // Overrun
    send_frame(8'h11, 1'b0, 1'b1, -1, -1);
    idle(4);
    apply_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, -1, -1);
    idle(4);
    apply_frame(8'h22, 1'b0, 1'b1);
    check_state("ovr");
    pop();
    check_state("ovr.clr");

    // Start-bit glitch
    s_in = 1'b0;
    repeat (CPB / 2 - 1) tick();
    idle(12);
    check_state("glitch");

    // ena paused inside data bit 3
    send_frame(8'h5A, 1'b0, 1'b1, 3, -1);
    idle(4);
    apply_frame(8'h5A, 1'b0, 1'b1);
    check_state("ena");
    pop();

    // Reset mid-DATA then a clean frame
    send_frame(8'hC3, 1'b0, 1'b1, -1, 3);
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    idle(6);
    check_state("midrst");
    send_frame(8'h81, 1'b0, 1'b1, -1, -1);
    idle(4);
    apply_frame(8'h81, 1'b0, 1'b1);
    check_state("post_rst");
    pop();

    // Back-to-back frames with the consumer always ready
    got_q.delete();
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b0, 1'b1, -1, -1);
    idle(8);
    rx_ready = 1'b0;
    chk("b2b.n", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) chk($sformatf("b2b.d%0d", i), got_q[i], b2b[i]);
    check_state("b2b");

    // Randomized frames with random error injection and draining
    for (int n = 0; n < 40; n++) begin
      d    = DW'($urandom);
      kind = $urandom_range(0, 5);
      send_frame(d, kind == 0, (kind == 1) ? 1'b0 : 1'b1, -1, -1);
      idle($urandom_range(4, 8));
      apply_frame(d, kind == 0, (kind == 1) ? 1'b0 : 1'b1);
      check_state($sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) != 0) pop();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial frame receiver that consumes the single-bit stream shifted out of the universal shift register's LSB when that register runs in right-shift mode (MSB>LSB).
- Detects a start bit, samples DATA_W data bits LSB-first, an optional even-parity bit and a stop bit, then presents the byte on a valid/ready output.
- Sits between the shift register's serial output and any byte-wide consumer on uo_out or an internal bus.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit (≥2, even).
- DATA_W, 8, data bits per frame.
- PARITY_EN, 1, 1 = even-parity bit present between data and stop; 0 = no parity bit.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- ena  in  1  clock enable; low freezes all state (counters, FSM, synchronizer)
- s_in  in  1  serial line, idles high
- rx_ready  in  1  consumer accepts rx_data when high with rx_valid
- rx_data  out  DATA_W  received byte, bit0 = first data bit received
- rx_valid  out  1  rx_data holds an unconsumed byte
- overrun  out  1  sticky: a good frame completed while rx_valid was high
- frame_err  out  1  1-cycle pulse: stop bit sampled low
- parity_err  out  1  1-cycle pulse: parity mismatch (PARITY_EN=1 only)

Behaviour:
- Reset (rst_n low at clk edge, takes priority over ena): FSM=IDLE; rx_data=0; rx_valid=0; overrun=0; frame_err=0; parity_err=0; synchronizer flops=1; counters=0.
- s_in goes through a 2-flop synchronizer; all decisions use the synchronized value s_sync.
- ena low: no state change except reset; pulses deassert; rx_valid/rx_data hold. The handshake is also ignored while ena is low.
- FSM states:
  - IDLE: on s_sync==0, go to START and clear the bit counter to 0.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If s_sync==1 (glitch), return to IDLE with no error. Otherwise go to DATA and clear the counter.
  - DATA: sample every CLKS_PER_BIT cycles. Shift the sample into a shift buffer at the MSB, shifting right so the first bit lands at bit0 after DATA_W samples. After DATA_W samples, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: sample one bit. Parity is good if XOR(data bits, parity bit)==0.
  - STOP: sample one bit, then go to IDLE. On the next cycle IDLE may detect a new start.
- Completion at the stop sample:
  - Stop bit = 0: frame_err pulses, byte discarded.
  - Else parity bad: parity_err pulses, byte discarded.
  - Else the frame is good.
- Good frame:
  - If rx_valid==0, or rx_valid & rx_ready in that same cycle: rx_data=byte and rx_valid=1 from the next cycle. Latency is 1 cycle after the stop sample.
  - Else: overrun=1, old rx_data retained, new byte dropped.
- Handshake: rx_valid & rx_ready & ena at an edge clears rx_valid and clears overrun, unless a good frame loads in that same edge (then rx_valid stays 1 with the new data).
- rx_data is stable while rx_valid is high.
- s_in toggling mid-frame does not abort a frame. Only the START glitch check aborts.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with s_in toggling -> all outputs 0, FSM IDLE; release, s_in=1 for 20 cycles -> rx_valid stays 0.
- Good frame: CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1), rx_ready=0 -> rx_valid=1, rx_data=0xA5, no error pulses. Then rx_ready=1 for one cycle -> rx_valid=0 next cycle.
- Errors: send 0x3C with parity bit 1 -> parity_err single-cycle pulse, rx_valid unchanged. Send 0x3C with correct parity and stop 0 -> frame_err pulse, no data.
- Overrun and glitch:
  - With 0x11 pending and rx_ready=0, send 0x22 -> overrun=1, rx_data stays 0x11; handshake -> overrun=0.
  - s_in low for 1 bit-time/2 - 1 cycles -> back to IDLE, no output.
- ena and reset mid-frame:
  - Drop ena for 10 cycles during bit 3 of 0x5A while holding s_in -> frame still decodes 0x5A after ena returns.
  - Assert rst_n=0 mid-DATA -> IDLE; a following 0x81 frame decodes correctly.
- Back-to-back: three frames 0x01, 0x80, 0xFF with no idle gap, rx_ready=1 -> three rx_valid pulses with data in order, no errors.
